// File: rtl/decade_seq_ctrl_pkg.sv
// Shared command codes, controller state encoding and BCD digit width.
package decade_seq_ctrl_pkg;

    localparam int DIGW = 4;

    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_CLEAR   = 3'd1;
    localparam logic [2:0] CMD_PRESET9 = 3'd2;
    localparam logic [2:0] CMD_RUN     = 3'd3;
    localparam logic [2:0] CMD_STOP    = 3'd4;
    localparam logic [2:0] CMD_STEP    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP_WAIT = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/decade_seq_ctrl_bcd_digit.sv
// One decade stage: registered 0..9 value with clear, preset-9 and ripple carry.
// inc_val is the would-be incremented value so the parent can match before committing.
module bcd_digit
    import decade_seq_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            pre9,
    input  logic            inc_en,
    input  logic            cin,
    output logic [DIGW-1:0] val,
    output logic [DIGW-1:0] inc_val,
    output logic            cout
);

    logic [DIGW-1:0] val_q;
    logic [DIGW-1:0] val_d;

    always_comb begin
        cout    = cin && (val_q == 4'd9);
        inc_val = val_q;
        if (cin) begin
            inc_val = (val_q == 4'd9) ? 4'd0 : val_q + 4'd1;
        end
        val_d = val_q;
        if (clr) begin
            val_d = 4'd0;
        end else if (pre9) begin
            val_d = 4'd9;
        end else if (inc_en) begin
            val_d = inc_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= 4'd0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val = val_q;

endmodule

// File: rtl/decade_seq_ctrl.sv
// Cascaded BCD counter with command-driven run/stop/step control and terminal-count detection.
// tc/ovf/count are registered; cmd_ready drops only while a single step waits for its tick.
module decade_seq_ctrl
    import decade_seq_ctrl_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd,
    output logic                 cmd_ready,
    input  logic                 tick,
    input  logic [DIGW*NDIG-1:0] limit,
    output logic [DIGW*NDIG-1:0] count,
    output logic                 busy,
    output logic                 tc,
    output logic                 ovf
);

    state_t state_q, state_d;
    logic   tc_q, tc_d;
    logic   ovf_q, ovf_d;

    logic                 clr, pre9, inc_en;
    logic                 acc, suppress;
    logic [NDIG:0]        carry;
    logic [DIGW*NDIG-1:0] inc_vec;
    logic                 lim_ok, match, wrap;

    assign carry[0] = 1'b1;

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_digit u_dig (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .pre9    (pre9),
            .inc_en  (inc_en),
            .cin     (carry[g]),
            .val     (count[g*DIGW +: DIGW]),
            .inc_val (inc_vec[g*DIGW +: DIGW]),
            .cout    (carry[g+1])
        );
    end

    // A limit with a non-decimal digit can never be reached, so it disables matching.
    always_comb begin
        lim_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (limit[i*DIGW +: DIGW] > 4'd9) begin
                lim_ok = 1'b0;
            end
        end
    end

    assign match = lim_ok && (inc_vec == limit);
    assign wrap  = carry[NDIG];

    always_comb begin
        acc      = cmd_valid && (state_q != ST_STEP_WAIT);
        clr      = acc && (cmd == CMD_CLEAR);
        pre9     = acc && (cmd == CMD_PRESET9);
        suppress = acc && (cmd != CMD_NOP) && (cmd != CMD_STEP) && (cmd != CMD_RUN);
        state_d  = state_q;
        inc_en   = 1'b0;
        tc_d     = 1'b0;
        ovf_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc && cmd == CMD_RUN) begin
                    state_d = ST_RUN;
                end else if (acc && cmd == CMD_STEP) begin
                    state_d = ST_STEP_WAIT;
                end
            end
            ST_RUN: begin
                if (acc && cmd == CMD_STOP) begin
                    state_d = ST_IDLE;
                end else begin
                    inc_en = tick && !suppress;
                end
            end
            ST_DONE: begin
                if (acc && cmd == CMD_RUN) begin
                    state_d = ST_RUN;
                end else if (acc && cmd == CMD_STEP) begin
                    state_d = ST_STEP_WAIT;
                end else if (acc && cmd == CMD_STOP) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP_WAIT: begin
                if (tick) begin
                    inc_en  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr || pre9) begin
            state_d = ST_IDLE;
        end
        if (inc_en) begin
            tc_d  = match;
            ovf_d = wrap;
            if (match) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cmd_ready = (state_q != ST_STEP_WAIT);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_STEP_WAIT);
    assign tc        = tc_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/decade_seq_ctrl.md
DECADE_SEQ_CTRL -- requirements
Module: decade_seq_ctrl

Interface
REQ-001 Parameter: NDIG, default 4, number of cascaded decade (BCD) digits, legal range 1..8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd  input  3  command code, see REQ-010.
REQ-006 cmd_ready  output  1  controller accepts a command this cycle.
REQ-007 tick  input  1  count-enable qualifier; one increment per cycle with tick=1 when counting.
REQ-008 limit  input  4*NDIG  BCD terminal value, digit 0 in bits [3:0]; sampled every cycle.
REQ-009 count  output  4*NDIG  current BCD count, same digit order; busy  output  1  state is RUN or STEP_WAIT; tc  output  1  one-cycle terminal-count pulse; ovf  output  1  one-cycle wrap pulse.

Function
REQ-010 Command codes: 0 NOP, 1 CLEAR (all digits 0), 2 PRESET9 (all digits 9), 3 RUN, 4 STOP, 5 STEP, 6-7 reserved (accepted, no effect).
REQ-011 A command is accepted on a cycle with cmd_valid=1 and cmd_ready=1; cmd_ready is 0 only in STEP_WAIT.
REQ-012 States: IDLE, RUN, STEP_WAIT, DONE.
REQ-013 IDLE: RUN -> RUN; STEP -> STEP_WAIT; CLEAR/PRESET9 load count, stay IDLE; STOP/NOP no effect.
REQ-014 RUN: tick=1 increments count by 1 in BCD, carry rippling digit 0 upward, result visible the next cycle.
REQ-015 RUN: STOP -> IDLE; CLEAR/PRESET9 load count -> IDLE; STEP and RUN accepted with no effect.
REQ-016 Any accepted command other than NOP, STEP or RUN suppresses that cycle's increment; the command wins over tick.
REQ-017 Terminal match is evaluated on the incremented value: when count+1 == limit, count takes that value, tc=1 the next cycle, state -> DONE.
REQ-018 Wrap: increment from all-9s yields all-0s with ovf=1 the next cycle; if limit is all-0s, tc and ovf pulse together.
REQ-019 A limit containing any digit > 9 never matches; counting wraps freely.
REQ-020 DONE: count held; RUN -> RUN, continues from held value (next match only after wrap-around); CLEAR/PRESET9 load -> IDLE; STEP -> STEP_WAIT; STOP -> IDLE.
REQ-021 STEP_WAIT: first cycle with tick=1 increments once, then -> DONE if REQ-017 matched, else -> IDLE; no commands accepted meanwhile.
REQ-022 tc and ovf are registered, high exactly one cycle per event, never high in consecutive cycles from one event.
REQ-023 Increment never occurs in IDLE or DONE regardless of tick.

Reset
REQ-024 rst=1 at a rising edge forces state IDLE, count all-0s, tc 0, ovf 0, overriding any command or tick that cycle.
REQ-025 Commands offered while rst=1 are discarded; cmd_ready=1 from the first cycle after rst falls.
REQ-026 Reset mid-RUN or mid-STEP_WAIT aborts the operation with no tc/ovf pulse.

Structure
REQ-027 Shared package holds command code constants, state enumeration, and BCD digit width constant (4).
REQ-028 One sub-module bcd_digit: single decade stage with clear, preset-9, carry-in, carry-out, 4-bit value; NDIG instances cascaded by generate.
REQ-029 Terminal match and wrap detection are combinational on the next-count vector; all outputs except cmd_ready and busy are registered.

Verification
REQ-030 Reset, RUN, tick=1 for 12 cycles, limit=9999 -> count 0012, tc never asserted, busy=1.
REQ-031 PRESET9 (NDIG=4), RUN, one tick, limit=0000 -> count 0000, tc=1 and ovf=1 same cycle, state DONE, busy=0.
REQ-032 limit=0005, RUN, ticks continuous -> count 0005 then held, tc one cycle only; further ticks leave 0005.
REQ-033 RUN with tick=1, CLEAR in cycle count=0037 -> next count 0000, no increment, state IDLE.
REQ-034 IDLE count 0008, STEP with tick=0 for 3 cycles -> cmd_ready=0, count 0008; tick=1 -> count 0009, back to IDLE, cmd_ready=1.
REQ-035 limit=00A0, RUN from 9998, 3 ticks -> 9999, 0000 (ovf=1), 0001; tc never asserted.
